aes_dec: RTL

Iterative AES-128 decryption core, one round per clock. It is the inverse-direction companion of the team's iterative AES-128 encryption core and uses the same bus-level handshake (`Din`/`Key`/`Dout`, `Drdy`/`Krdy`, `BSY`/`Dvld`), so the two are drop-in interchangeable on the crypto wrapper. Because decryption consumes round keys in reverse order, the block runs a forward key expansion once per key load and stores the final round key (K10). Each block then walks the schedule backwards on the fly.

---
 rtl/aes_dec_if.sv | 26 ++
 rtl/aes_dec.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_if.sv
// Bus bundle of the iterative AES-128 decryption core: enable, key/data load and result.
// Latency: none, wires only.
// Backpressure: requests are honoured only while BSY is low; no queueing.
interface aes_dec_if;
   logic         EN;
   logic [127:0] Key;
   logic         Krdy;
   logic [127:0] Din;
   logic         Drdy;
   logic [127:0] Dout;
   logic         Dvld;
   logic         Kvld;
   logic         BSY;

   // Requester side: drives key/data, watches result and status
   modport master (
      output EN, Key, Krdy, Din, Drdy,
      input  Dout, Dvld, Kvld, BSY
   );

   // Core side
   modport slave (
      input  EN, Key, Krdy, Din, Drdy,
      output Dout, Dvld, Kvld, BSY
   );
endinterface

// File: rtl/aes_dec.sv
// Iterative AES-128 decryption, one round per clock; forward key expansion once per key, schedule walked back per block.
// Latency: key load 11 cycles (Krdy edge to Kvld), decrypt 11 cycles (Drdy edge to Dvld); EN=0 stretches both.
// Backpressure: Krdy/Drdy are ignored while BSY=1 and Drdy is ignored until Kvld=1; nothing is queued.
module aes_dec (
   input  logic    CLK,
   input  logic    RST,
   aes_dec_if.slave bus
);

   typedef enum logic [1:0] {IDLE, KEXP, DEC} mode_t;

   // rcon bytes indexed by the one-hot round counter bit position
   localparam logic [79:0] RCON_TBL = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                       8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

   mode_t        mode, mode_nxt;
   logic [127:0] krg, krg_nxt;
   logic [127:0] klast_rg, klast_rg_nxt;
   logic [127:0] krg_x, krg_x_nxt;
   logic [127:0] drg, drg_nxt;
   logic [9:0]   rrg, rrg_nxt;
   logic         dvld, dvld_nxt;
   logic         kvld, kvld_nxt;

   logic [127:0] kexp_out;
   logic [127:0] inv_src;
   logic [7:0]   inv_rc;
   logic [127:0] inv_out;
   logic [127:0] round_key;
   logic [127:0] round_pre;
   logic [127:0] round_out;

   // ---------------- GF(2^8) helpers ----------------
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = '0;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box needs)
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] x2, x3, x12, x15, x240;
      x2   = gmul(x, x);
      x3   = gmul(x2, x);
      x12  = gmul(gmul(x3, x3), gmul(x3, x3));
      x15  = gmul(x12, x3);
      x240 = x15;
      for (int i = 0; i < 4; i++) x240 = gmul(x240, x240);
      return gmul(gmul(x240, x12), x2);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
   endfunction

   // ---------------- key schedule steps ----------------
   function automatic logic [7:0] rcon_of(input logic [9:0] r);
      logic [7:0] rc;
      rc = '0;
      for (int i = 0; i < 10; i++) begin
         if (r[i]) rc = rc | RCON_TBL[8*i +: 8];
      end
      return rc;
   endfunction

   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0]  ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] inv_kexp(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w3 = k[31:0]  ^ k[63:32];
      w2 = k[63:32] ^ k[95:64];
      w1 = k[95:64] ^ k[127:96];
      w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
      return {w0, w1, w2, w3};
   endfunction

   // ---------------- inverse round pieces ----------------
   // Byte (row r, column c) lives at index 4*c+r, byte 0 in the top bits
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   // Shared datapath: one forward key step, one inverse key step, one inverse round
   always_comb begin
      kexp_out  = kexp(krg_x, rcon_of(rrg));
      // At block start the inverse step derives K9 from K10; during DEC it steps the working key
      inv_src   = (mode == IDLE) ? klast_rg : krg_x;
      inv_rc    = (mode == IDLE) ? 8'h36 : rcon_of({rrg[0], rrg[9:1]});
      inv_out   = inv_kexp(inv_src, inv_rc);
      // Last round needs K0, which is already held in krg
      round_key = rrg[0] ? krg : krg_x;
      round_pre = inv_sub_bytes(inv_shift_rows(drg)) ^ round_key;
      round_out = rrg[0] ? round_pre : inv_mix_columns(round_pre);
   end

   // Next-state and register-update selection for the IDLE/KEXP/DEC sequencer
   always_comb begin
      mode_nxt     = mode;
      krg_nxt      = krg;
      klast_rg_nxt = klast_rg;
      krg_x_nxt    = krg_x;
      drg_nxt      = drg;
      rrg_nxt      = rrg;
      dvld_nxt     = dvld;
      kvld_nxt     = kvld;
      case (mode)
         IDLE: begin
            if (bus.Krdy) begin
               krg_nxt   = bus.Key;
               krg_x_nxt = bus.Key;
               rrg_nxt   = 10'b0000000001;
               kvld_nxt  = 1'b0;
               dvld_nxt  = 1'b0;
               mode_nxt  = KEXP;
            end else if (bus.Drdy && kvld) begin
               drg_nxt   = bus.Din ^ klast_rg;
               krg_x_nxt = inv_out;
               rrg_nxt   = 10'b1000000000;
               dvld_nxt  = 1'b0;
               mode_nxt  = DEC;
            end
         end
         KEXP: begin
            krg_x_nxt = kexp_out;
            rrg_nxt   = {rrg[8:0], rrg[9]};
            if (rrg[9]) begin
               klast_rg_nxt = kexp_out;
               rrg_nxt      = 10'b0000000001;
               kvld_nxt     = 1'b1;
               mode_nxt     = IDLE;
            end
         end
         DEC: begin
            drg_nxt   = round_out;
            krg_x_nxt = inv_out;
            rrg_nxt   = {rrg[0], rrg[9:1]};
            if (rrg[0]) begin
               dvld_nxt = 1'b1;
               mode_nxt = IDLE;
            end
         end
         default: mode_nxt = IDLE;
      endcase
   end

   // State register: synchronous reset wins, EN=0 freezes everything
   always_ff @(posedge CLK) begin
      if (RST) begin
         mode     <= IDLE;
         krg      <= '0;
         klast_rg <= '0;
         krg_x    <= '0;
         drg      <= '0;
         rrg      <= 10'b0000000001;
         dvld     <= 1'b0;
         kvld     <= 1'b0;
      end else if (bus.EN) begin
         mode     <= mode_nxt;
         krg      <= krg_nxt;
         klast_rg <= klast_rg_nxt;
         krg_x    <= krg_x_nxt;
         drg      <= drg_nxt;
         rrg      <= rrg_nxt;
         dvld     <= dvld_nxt;
         kvld     <= kvld_nxt;
      end
   end

   assign bus.Dout = drg;
   assign bus.Dvld = dvld;
   assign bus.Kvld = kvld;
   assign bus.BSY  = (mode != IDLE);

endmodule
